// File: rtl/cpuclk_align_if.sv
// CPU clock aligner bus: host/decode inputs and CPU clock outputs.
// The master side drives the controls; the slave side is the clock generator.
interface cpuclk_align_if #(
    parameter int DIV_W = 4,
    parameter int CNT_W = 16
);
    logic             host_phi0;
    logic             hs_en;
    logic [DIV_W-1:0] div_sel;
    logic             cycle_is_host;
    logic             cnt_clr;
    logic             cpu_phi2;
    logic             host_cycle;
    logic             cycle_end;
    logic [CNT_W-1:0] host_wait_cnt;

    modport master (
        output host_phi0, hs_en, div_sel, cycle_is_host, cnt_clr,
        input  cpu_phi2, host_cycle, cycle_end, host_wait_cnt
    );

    modport slave (
        input  host_phi0, hs_en, div_sel, cycle_is_host, cnt_clr,
        output cpu_phi2, host_cycle, cycle_end, host_wait_cnt
    );
endinterface

// File: rtl/cpuclk_align_m.sv
// Single-domain CPU clock generator: fast divided cycles, or cycles stretched so
// CPU PHI2 overlaps a full host PHI0 high phase.
//   state     | meaning
//   PH1       | CPU PHI1 (low), counting down the low half-period
//   PH2       | fast CPU PHI2 (high), counting down div_lat
//   WAIT_RISE | CPU low, waiting for a synchronised host PHI0 rising edge
//   HOST_PH2  | CPU high, waiting for the host PHI0 falling edge
//   HOLD      | CPU high for HOLD_CYCLES after the host fall
module cpuclk_align_m #(
    parameter int DIV_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input logic            hsclk,
    input logic            resetb,
    cpuclk_align_if.slave  bus
);

    typedef enum logic [2:0] {
        PH1       = 3'd0,
        PH2       = 3'd1,
        WAIT_RISE = 3'd2,
        HOST_PH2  = 3'd3,
        HOLD      = 3'd4
    } state_t;

    localparam logic [DIV_W-1:0] HOLD_INIT = DIV_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ph0_s, ph0_p, rise, fall;
    logic [DIV_W-1:0]       cnt, cnt_nxt, div_lat, div_lat_nxt;
    logic                   need_host;
    logic                   phi2_q, host_q, end_q;
    logic                   phi2_nxt, host_nxt, end_nxt;
    logic [CNT_W-1:0]       wait_cnt;

    assign ph0_s = sync_q[SYNC_STAGES-1];
    assign rise  = ph0_s & ~ph0_p;
    assign fall  = ~ph0_s & ph0_p;

    always_ff @(posedge hsclk or negedge resetb) begin
        if (!resetb) begin
            sync_q <= '0;
            ph0_p  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.host_phi0};
            ph0_p  <= ph0_s;
        end
    end

    always_ff @(posedge hsclk or negedge resetb) begin
        if (!resetb) begin
            state   <= PH1;
            cnt     <= '0;
            div_lat <= '0;
            phi2_q  <= 1'b0;
            host_q  <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            div_lat <= div_lat_nxt;
            phi2_q  <= phi2_nxt;
            host_q  <= host_nxt;
            end_q   <= end_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        div_lat_nxt = div_lat;
        need_host   = bus.cycle_is_host | ~bus.hs_en;
        case (state)
            PH1: begin
                if (cnt == '0) begin
                    if (need_host) begin
                        state_nxt = WAIT_RISE;
                    end else begin
                        state_nxt = PH2;
                        cnt_nxt   = div_lat;
                    end
                end else begin
                    cnt_nxt = cnt - DIV_W'(1);
                end
            end
            PH2, HOLD: begin
                if (cnt == '0) begin
                    state_nxt   = PH1;
                    cnt_nxt     = bus.div_sel;
                    div_lat_nxt = bus.div_sel;
                end else begin
                    cnt_nxt = cnt - DIV_W'(1);
                end
            end
            WAIT_RISE: begin
                if (rise) state_nxt = HOST_PH2;
            end
            HOST_PH2: begin
                if (fall) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_INIT;
                end
            end
            default: state_nxt = PH1;
        endcase
        // Outputs are registered from the next state so they track the state flop exactly.
        phi2_nxt = (state_nxt == PH2) || (state_nxt == HOST_PH2) || (state_nxt == HOLD);
        host_nxt = (state_nxt == WAIT_RISE) || (state_nxt == HOST_PH2) || (state_nxt == HOLD);
        end_nxt  = (state_nxt == PH1) && ((state == PH2) || (state == HOLD));
    end

    always_ff @(posedge hsclk or negedge resetb) begin
        if (!resetb) begin
            wait_cnt <= '0;
        end else if (bus.cnt_clr) begin
            wait_cnt <= '0;
        end else if ((state == WAIT_RISE) && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign bus.cpu_phi2      = phi2_q;
    assign bus.host_cycle    = host_q;
    assign bus.cycle_end     = end_q;
    assign bus.host_wait_cnt = wait_cnt;

endmodule

// File: tb/tb_cpuclk_align_m.sv
// Randomised bench for cpuclk_align_m: an edge-time model predicts each CPU cycle's
// PHI2 rise/fall edges, host flag and wait count; a monitor compares at cycle_end.
module tb_cpuclk_align_m;
    localparam int DIV_W       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int HOLD_CYCLES = 1;
    localparam int CNT_W       = 4;
    localparam int HOST_PER    = 16;
    localparam int CNT_SAT     = (1 << CNT_W) - 1;

    typedef struct {
        int   rise;
        int   fall;
        logic host;
        int   wcnt;
    } exp_t;

    typedef struct {
        logic hs;
        logic cih;
        int   div;
    } cfg_t;

    logic hsclk = 1'b0;
    logic resetb = 1'b0;
    int   cyc = 0;
    int   host_off = 0;
    int   rel_edge = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t expq[$];

    int   t_cur, lat_cur, acc;
    cfg_t cur;

    cpuclk_align_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

    cpuclk_align_m #(
        .DIV_W(DIV_W), .SYNC_STAGES(SYNC_STAGES),
        .HOLD_CYCLES(HOLD_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .hsclk(hsclk),
        .resetb(resetb),
        .bus(bus.slave)
    );

    always #5 hsclk = ~hsclk;
    always @(posedge hsclk) cyc <= cyc + 1;

    // host PHI0 level sampled at edge n: 8 high / 8 low with a random phase
    function automatic logic host_lvl(input int n);
        return ((n + host_off) % HOST_PER) < (HOST_PER / 2);
    endfunction

    // what the synchroniser has captured at edge n (flops held clear through reset)
    function automatic logic seen(input int n);
        if (n <= rel_edge) return 1'b0;
        return host_lvl(n);
    endfunction

    always @(negedge hsclk) bus.host_phi0 = host_lvl(cyc + 1);

    function automatic int sat(input int v);
        return (v > CNT_SAT) ? CNT_SAT : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle starting with PH1 entry at edge t: low lasts lat+1, then either a fast
    // high of lat+1, or a wait for the next host rise and a high until host fall.
    task automatic model_cycle(input int t, input int lat, input logic hs, input logic cih,
                               output int x, output int rise, output int fall,
                               output logic host);
        int e, f;
        x    = t + lat + 1;
        host = cih | ~hs;
        if (!host) begin
            rise = x;
            fall = x + lat + 1;
        end else begin
            e = x - SYNC_STAGES + 1;
            while (!(seen(e) && !seen(e - 1))) e++;
            rise = e + SYNC_STAGES;
            f = e + 1;
            while (!(!seen(f) && seen(f - 1))) f++;
            fall = f + SYNC_STAGES + HOLD_CYCLES;
        end
    endtask

    task automatic wait_edge(input int n);
        while (cyc < n) @(negedge hsclk);
    endtask

    task automatic apply(input cfg_t c);
        bus.hs_en         = c.hs;
        bus.cycle_is_host = c.cih;
        bus.div_sel       = DIV_W'(c.div);
    endtask

    function automatic cfg_t rand_cfg();
        cfg_t c;
        int   r;
        r     = $urandom_range(0, 3);
        c.hs  = (r != 3);
        c.cih = (r == 2) ? 1'b1 : ((r == 3) ? 1'(($urandom_range(0, 1))) : 1'b0);
        c.div = $urandom_range(0, 7);
        return c;
    endfunction

    function automatic cfg_t mk_cfg(input logic hs, input logic cih, input int div);
        cfg_t c;
        c.hs = hs; c.cih = cih; c.div = div;
        return c;
    endfunction

    // Runs one CPU cycle; the next cycle's config lands somewhere after this PH1 exit.
    task automatic run_cycle(input cfg_t nxt);
        int   x, rise, fall, c, a, len;
        logic host;
        model_cycle(t_cur, lat_cur, cur.hs, cur.cih, x, rise, fall, host);
        len = host ? (rise - x) : 0;
        c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(t_cur + 1, fall - 1)) : -1;
        if (c < 0)          acc = sat(acc + len);
        else if (c <= x)    acc = sat(len);
        else if (c <= rise) acc = sat(rise - c);
        else                acc = 0;
        expq.push_back('{rise, fall, host, acc});
        a = $urandom_range(x, fall - 1);
        for (int n = t_cur; n < fall; n++) begin
            wait_edge(n);
            bus.cnt_clr = (n + 1 == c);
            if (n == a) apply(nxt);
        end
        t_cur   = fall;
        lat_cur = nxt.div;
        cur     = nxt;
    endtask

    initial begin : monitor
        logic prev;
        int   r_t, f_t;
        logic hc_r;
        exp_t e;
        prev = 1'b0; r_t = -1; f_t = -1; hc_r = 1'b0;
        forever begin
            @(posedge hsclk);
            #1;
            if (!resetb) begin
                prev = 1'b0; r_t = -1; f_t = -1;
                continue;
            end
            if (bus.cpu_phi2 && !prev) begin
                r_t  = cyc;
                hc_r = bus.host_cycle;
            end
            if (!bus.cpu_phi2 && prev) f_t = cyc;
            prev = bus.cpu_phi2;
            if (bus.cycle_end) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_cycle_end: got pulse, expected none (edge %0d)", cyc);
                end else begin
                    e = expq.pop_front();
                    check("phi2_rise_edge", r_t, e.rise);
                    check("phi2_fall_edge", f_t, e.fall);
                    check("host_cycle", int'(hc_r), int'(e.host));
                    check("host_wait_cnt", int'(bus.host_wait_cnt), e.wcnt);
                end
            end
        end
    end

    initial begin : stim
        int   x, rise, fall;
        logic host;
        cfg_t nxt;
        host_off    = $urandom_range(0, HOST_PER - 1);
        bus.cnt_clr = 1'b0;
        cur = mk_cfg(1'b1, 1'b0, 3);
        apply(cur);
        repeat (3) @(negedge hsclk);
        rel_edge = cyc;
        t_cur = cyc; lat_cur = 0; acc = 0;
        resetb = 1'b1;

        // divider 4/4, switch to 2/2 mid-PH2, then random mix ending on a host cycle
        for (int k = 0; k < 40; k++) begin
            if (k < 3)       nxt = mk_cfg(1'b1, 1'b0, 3);
            else if (k < 6)  nxt = mk_cfg(1'b1, 1'b0, 1);
            else if (k == 39) nxt = mk_cfg(1'b1, 1'b1, 2);
            else             nxt = rand_cfg();
            run_cycle(nxt);
        end

        // reset asserted while CPU PHI2 is stretched over host PHI0
        model_cycle(t_cur, lat_cur, cur.hs, cur.cih, x, rise, fall, host);
        wait_edge(rise + 1);
        check("queue_drained_before_reset", expq.size(), 0);
        check("phi2_high_before_reset", int'(bus.cpu_phi2), 1);
        check("host_cycle_before_reset", int'(bus.host_cycle), 1);
        #2 resetb = 1'b0;
        #1;
        check("reset_cpu_phi2", int'(bus.cpu_phi2), 0);
        check("reset_host_cycle", int'(bus.host_cycle), 0);
        check("reset_cycle_end", int'(bus.cycle_end), 0);
        check("reset_host_wait_cnt", int'(bus.host_wait_cnt), 0);

        repeat (2) @(negedge hsclk);
        cur = mk_cfg(1'b1, 1'b0, 0);
        apply(cur);
        rel_edge = cyc;
        t_cur = cyc; lat_cur = 0; acc = 0;
        resetb = 1'b1;
        for (int k = 0; k < 30; k++) begin
            nxt = (k < 4) ? mk_cfg(1'b1, 1'b0, 0) : rand_cfg();
            run_cycle(nxt);
        end

        wait_edge(t_cur + 2);
        check("queue_empty_at_end", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpuclk_align_m.md
# cpuclk_align_m

Parametrised CPU clock generator for the accelerator CPLD. It replaces the two-clock mux with a single-domain state machine running on `hsclk`. It divides `hsclk` by a programmable ratio for fast cycles, and stretches individual cycles so that CPU PHI2 overlaps a full host PHI2 (`host_phi0` high) whenever the cycle targets the host bus. It sits between the mapping/decode logic, which supplies `cycle_is_host`, and the CPU clock pin. It also reports cycle boundaries and host-wait statistics.

## Interface
Parameters:
- `DIV_W`, default 4: width of the divider select.
- `SYNC_STAGES`, default 2: synchroniser flops on `host_phi0` (legal values are 2 or more).
- `HOLD_CYCLES`, default 1: `hsclk` cycles that CPU PHI2 stays high after the host PHI0 fall is detected (legal values are 1 or more).
- `CNT_W`, default 16: width of the host-wait counter.

Ports:
- `hsclk`, in, 1: high-speed clock. All flops run on its rising edge.
- `resetb`, in, 1: reset, asynchronous, active-low.
- `host_phi0`, in, 1: host bus PHI0. Asynchronous to `hsclk`.
- `hs_en`, in, 1: enables fast cycles. When 0, every cycle is a host cycle.
- `div_sel`, in, `DIV_W`: fast half-period minus 1, in `hsclk` cycles.
- `cycle_is_host`, in, 1: the current cycle targets the host bus. Valid by the end of PHI1.
- `cnt_clr`, in, 1: synchronous clear of `host_wait_cnt`.
- `cpu_phi2`, out, 1: CPU PHI2. Driven directly from a flop and glitch-free.
- `host_cycle`, out, 1: the current cycle is host-aligned.
- `cycle_end`, out, 1: one-`hsclk` pulse on the cycle following each `cpu_phi2` fall.
- `host_wait_cnt`, out, `CNT_W`: saturating count of `hsclk` cycles spent in WAIT_RISE.

## Operation
- The synchroniser is a `SYNC_STAGES`-flop chain ending in `ph0_s`, plus a delayed copy `ph0_p`.
  - rise = `ph0_s & !ph0_p`.
  - fall = `!ph0_s & ph0_p`.
- Phase counter `cnt`, width `DIV_W`. `div_lat` holds `div_sel` and is loaded on every entry to PH1.
- States and `cpu_phi2` level:
  - PH1 (0): decrements `cnt`. At `cnt==0`, evaluate `need_host = cycle_is_host | !hs_en`.
    - If `need_host=1`, go to WAIT_RISE.
    - Otherwise go to PH2 with `cnt=div_lat`.
  - PH2 (1): decrements `cnt`. At `cnt==0`, go to PH1 with `cnt=div_sel` and `div_lat=div_sel`.
  - WAIT_RISE (0): waits for a detected rise, then goes to HOST_PH2. A `host_phi0` level that is already high does not count as a rise; the block waits for the next rising edge. `host_wait_cnt` increments each cycle spent here.
  - HOST_PH2 (1): waits for a detected fall, then goes to HOLD with `cnt=HOLD_CYCLES-1`.
  - HOLD (1): decrements `cnt`. At `cnt==0`, go to PH1 with `cnt=div_sel` and `div_lat=div_sel`.
- `cpu_phi2` is registered and equals 1 in PH2, HOST_PH2 and HOLD.
- `host_cycle` is registered and equals 1 in WAIT_RISE, HOST_PH2 and HOLD.
- `cycle_end` is registered. It is 1 on the first cycle of PH1 after leaving PH2 or HOLD.
- `host_wait_cnt` saturates at all-ones. `cnt_clr` takes priority over increment.
- `div_sel` changes take effect only at the next PH1 entry. A mid-phase change has no effect.
- If `hs_en` falls mid-PH2, the current fast cycle completes. The next PH1 exit goes to the host path.

## Timing
- Reset (async assert): state=PH1, `cnt=0`, `div_lat=0`, all sync flops 0. Outputs: `cpu_phi2=0`, `host_cycle=0`, `cycle_end=0`, `host_wait_cnt=0`.
  - `cpu_phi2` drops immediately if it was high, including mid-HOST_PH2.
  - On release, the first PH1 lasts 1 cycle. The next PH1 exit then takes the host path unless `hs_en=1` and `cycle_is_host=0`.
- Fast cycle: PH1 and PH2 each last `div_sel+1` `hsclk` cycles. Period is `2*(div_sel+1)`. With `div_sel=0`, the output is `hsclk/2` at 50% duty.
- Host rise to `cpu_phi2` rise: `SYNC_STAGES` to `SYNC_STAGES+1` `hsclk` edges, depending on sampling phase.
- Host fall to `cpu_phi2` fall: `SYNC_STAGES + HOLD_CYCLES` to `SYNC_STAGES + HOLD_CYCLES + 1` edges.
- The PH1 following a host cycle lasts `div_sel+1` cycles, which guarantees a minimum CPU PHI1.
- `cycle_is_host` is sampled only on the PH1 cycle where `cnt==0`.

## Test plan
- Reset: assert `resetb` mid-HOST_PH2. Outputs go to 0 asynchronously and `host_wait_cnt=0`. After release, with `hs_en=1`, `cycle_is_host=0` and `div_sel=0`, `cpu_phi2` toggles every `hsclk` cycle.
- Divider: `div_sel=3`, `hs_en=1`, `cycle_is_host=0`. `cpu_phi2` is 4 low / 4 high. Change to `div_sel=1` mid-PH2; the new 2/2 timing starts at the next PH1. `host_cycle` stays 0 throughout.
- Host alignment: `host_phi0` period 16 `hsclk` (8/8), `cycle_is_host=1`, `SYNC_STAGES=2`, `HOLD_CYCLES=1`.
  - `cpu_phi2` rises 2–3 edges after `host_phi0` rises and falls 3–4 edges after it falls.
  - `cycle_end` pulses once per cycle.
- Entry with `host_phi0` already high: the block stays in WAIT_RISE until the next rising edge, and `host_wait_cnt` increases by the wait length.
- `hs_en=0` with `cycle_is_host=0`: every cycle is host-aligned and `host_cycle=1` during each PHI2. Deassert `hs_en` mid-PH2; that fast cycle completes first.
- Counter: with `CNT_W=4`, a long wait saturates `host_wait_cnt` at 15. Asserting `cnt_clr` together with an increment gives 0 on the next cycle.
